key_event_ctrl: RTL and testbench
=================================

KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 200000, number of consecutive stable synchronized samples required to accept a press or a release; legal range is 2 or more.
REQ-002 Port: clock  in  1  system clock; all state updates on the rising edge.
REQ-003 Port: reset  in  1  reset; synchronous, active-high.
REQ-004 Port: btn_submit  in  1  raw, asynchronous, bouncing submit push-button level.
REQ-005 Port: btn_status  in  1  raw, asynchronous, bouncing status push-button level.
REQ-006 Port: switches  in  24  raw board switch levels.
REQ-007 Port: SwitchCtrl  in  1  switch-region address decode from the memory/IO unit.
REQ-008 Port: ioRead  in  1  CPU IO read strobe.
REQ-009 Port: switchAddr  in  3  sub-address within the switch region.
REQ-010 Port: submit_posedge  out  1  sticky "submit pressed, not yet consumed" flag.
REQ-011 Port: status_posedge  out  1  sticky "status pressed, not yet consumed" flag.
REQ-012 Port: snap_switches  out  24  switch value captured at the last accepted submit press.

Function
REQ-013 Each button SHALL pass through a two-flop synchronizer before any other use, adding 2 cycles of latency.
REQ-014 Each button SHALL run an independent four-state FSM: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-015 IDLE to PRESS_WAIT SHALL occur when the synchronized level is 1; the debounce counter is cleared on entry.
REQ-016 In PRESS_WAIT, the counter SHALL increment while the level is 1; a 0 returns the FSM to IDLE with the counter cleared.
REQ-017 PRESS_WAIT to HELD SHALL occur on the cycle the counter equals DEBOUNCE_CYCLES-1 with the level still 1; a one-cycle accept pulse is generated in that same cycle.
REQ-018 HELD to RELEASE_WAIT SHALL occur when the level is 0, with the counter cleared; no further pulse is generated while in HELD, however long the button is held.
REQ-019 In RELEASE_WAIT, a level of 1 SHALL return the FSM to HELD; DEBOUNCE_CYCLES consecutive 0 samples SHALL return it to IDLE.
REQ-020 The counter SHALL be sized as clog2(DEBOUNCE_CYCLES) bits and SHALL never wrap.
REQ-021 A consuming read SHALL be defined as SwitchCtrl=1, ioRead=1 and switchAddr=3'b011 (submit) or 3'b100 (status).
REQ-022 The submit accept pulse SHALL set submit_posedge on the next edge.
REQ-023 A consuming read at 3'b011 SHALL clear submit_posedge on the next edge.
REQ-024 If a submit accept pulse and a submit consuming read occur in the same cycle, the set SHALL win and submit_posedge remains 1.
REQ-025 status_posedge SHALL behave identically to submit_posedge, using the status accept pulse and consuming reads at 3'b100.
REQ-026 A consuming read that matches one flag's address SHALL never affect the other flag.
REQ-027 snap_switches SHALL load the 24-bit switches value, sampled in the same cycle as the submit accept pulse, on the next edge; it holds otherwise.
REQ-028 A new accepted press while its flag is already 1 SHALL leave the flag at 1 (events do not queue) and SHALL still update snap_switches.
REQ-029 Reads at any other switchAddr, or with ioRead=0, SHALL have no effect on any state.

Reset
REQ-030 While reset=1 on a clock edge, all of the following SHALL be forced:
- both FSMs to IDLE;
- both counters to 0;
- synchronizer flops to 0;
- submit_posedge=0, status_posedge=0, snap_switches=24'h000000.
REQ-031 Reset asserted mid-debounce or mid-hold SHALL discard that press entirely; a button still held after reset is accepted only after a full new DEBOUNCE_CYCLES window.

Structure
REQ-032 A shared package SHALL hold:
- the FSM state encoding (2-bit: IDLE=0, PRESS_WAIT=1, HELD=2, RELEASE_WAIT=3);
- address constants ADDR_SUBMIT=3'b011 and ADDR_STATUS=3'b100.
REQ-033 The synchronizer, FSM and counter SHALL form one sub-module, debounce_fsm (ports: clock, reset, raw_in, accept_pulse), instantiated twice.
REQ-034 Flag, clear-arbitration and snapshot logic SHALL reside in key_event_ctrl.

Verification (DEBOUNCE_CYCLES=4)
REQ-035 Clean submit press held for 20 cycles with switches=24'hA5_1234 -> submit_posedge rises exactly 2+4+1 cycles after btn_submit rises, exactly once; snap_switches=24'hA51234.
REQ-036 Submit level toggling 1,0,1,0 on consecutive cycles, then 0 -> submit_posedge stays 0 and the FSM returns to IDLE.
REQ-037 submit_posedge=1, then a read at switchAddr=3'b011 -> flag 0 next edge, status_posedge unchanged; a read at 3'b100 instead -> submit_posedge stays 1.
REQ-038 Accept pulse and consuming read in the same cycle -> submit_posedge remains 1.
REQ-039 Reset asserted during PRESS_WAIT with the button held -> all outputs 0; the flag sets only after 2+4+1 cycles past reset deassertion.
REQ-040 Both buttons pressed simultaneously -> both flags set on the same edge; clearing one leaves the other at 1.

Source files
------------

// File: rtl/key_event_ctrl_pkg.sv
// Shared types and constants for the key event controller.
package key_event_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } db_state_t;

  localparam logic [2:0] ADDR_SUBMIT = 3'b011;
  localparam logic [2:0] ADDR_STATUS = 3'b100;

endpackage

// File: rtl/key_event_ctrl_debounce_fsm.sv
// Button synchronizer plus press/release debounce FSM with a one-cycle accept pulse.
//
// state           | meaning
// ST_IDLE         | button released and stable
// ST_PRESS_WAIT   | level high, counting stable high samples
// ST_HELD         | press accepted, waiting for level to drop
// ST_RELEASE_WAIT | level low, counting stable low samples
module debounce_fsm
  import key_event_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_in,
  output logic accept_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_0;
  logic          sync_1;
  db_state_t     state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_0 <= 1'b0;
      sync_1 <= 1'b0;
      state  <= ST_IDLE;
      cnt    <= '0;
    end else begin
      sync_0 <= raw_in;
      sync_1 <= sync_0;
      case (state)
        ST_IDLE: begin
          if (sync_1) begin
            state <= ST_PRESS_WAIT;
            cnt   <= '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (!sync_1) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_HELD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_HELD: begin
          if (!sync_1) begin
            state <= ST_RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        ST_RELEASE_WAIT: begin
          if (sync_1) begin
            state <= ST_HELD;
          end else if (cnt == CNT_LAST) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Decoded in the same cycle as the PRESS_WAIT -> HELD transition.
  assign accept_pulse = (state == ST_PRESS_WAIT) && sync_1 && (cnt == CNT_LAST);

endmodule

// File: rtl/key_event_ctrl.sv
// Debounced submit/status buttons exposed as sticky, read-to-clear event flags
// plus a snapshot of the switches taken at each accepted submit press.
module key_event_ctrl
  import key_event_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_submit,
  input  logic        btn_status,
  input  logic [23:0] switches,
  input  logic        SwitchCtrl,
  input  logic        ioRead,
  input  logic [2:0]  switchAddr,
  output logic        submit_posedge,
  output logic        status_posedge,
  output logic [23:0] snap_switches
);

  logic submit_accept;
  logic status_accept;
  logic read_submit;
  logic read_status;

  debounce_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_submit_db (
    .clock        (clock),
    .reset        (reset),
    .raw_in       (btn_submit),
    .accept_pulse (submit_accept)
  );

  debounce_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_status_db (
    .clock        (clock),
    .reset        (reset),
    .raw_in       (btn_status),
    .accept_pulse (status_accept)
  );

  assign read_submit = SwitchCtrl && ioRead && (switchAddr == ADDR_SUBMIT);
  assign read_status = SwitchCtrl && ioRead && (switchAddr == ADDR_STATUS);

  // A new press beats a same-cycle consuming read so no event is lost.
  always_ff @(posedge clock) begin
    if (reset) begin
      submit_posedge <= 1'b0;
      status_posedge <= 1'b0;
      snap_switches  <= 24'h000000;
    end else begin
      if (submit_accept) begin
        submit_posedge <= 1'b1;
        snap_switches  <= switches;
      end else if (read_submit) begin
        submit_posedge <= 1'b0;
      end
      if (status_accept) begin
        status_posedge <= 1'b1;
      end else if (read_status) begin
        status_posedge <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl with a short debounce window.
`timescale 1ns/1ps
module tb_key_event_ctrl;
  import key_event_ctrl_pkg::*;

  localparam int DB = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        btn_submit = 1'b0;
  logic        btn_status = 1'b0;
  logic [23:0] switches = 24'h0;
  logic        SwitchCtrl = 1'b0;
  logic        ioRead = 1'b0;
  logic [2:0]  switchAddr = 3'b000;
  logic        submit_posedge;
  logic        status_posedge;
  logic [23:0] snap_switches;

  int tests_run = 0;
  int tests_failed = 0;

  key_event_ctrl #(.DEBOUNCE_CYCLES(DB)) u_dut (
    .clock          (clock),
    .reset          (reset),
    .btn_submit     (btn_submit),
    .btn_status     (btn_status),
    .switches       (switches),
    .SwitchCtrl     (SwitchCtrl),
    .ioRead         (ioRead),
    .switchAddr     (switchAddr),
    .submit_posedge (submit_posedge),
    .status_posedge (status_posedge),
    .snap_switches  (snap_switches)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_read(input logic [2:0] addr, input logic ctrl, input logic rd);
    SwitchCtrl = ctrl;
    ioRead     = rd;
    switchAddr = addr;
    tick();
    SwitchCtrl = 1'b0;
    ioRead     = 1'b0;
    switchAddr = 3'b000;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    tests_run++;
    if (submit_posedge !== 1'b0 || status_posedge !== 1'b0 || snap_switches !== 24'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b %b %h, want 0 0 000000", submit_posedge, status_posedge, snap_switches);
    end
    tests_run++;
    if (u_dut.u_submit_db.state !== ST_IDLE || u_dut.u_status_db.state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d %0d, want 0 0", u_dut.u_submit_db.state, u_dut.u_status_db.state);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_clean_press();
    int n;
    switches   = 24'hA51234;
    btn_submit = 1'b1;
    n = 0;
    while (submit_posedge !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    tests_run++;
    if (n !== 7) begin
      tests_failed++;
      $display("FAIL press_latency: got %0d cycles, want 7", n);
    end
    switches = 24'h0F0F0F;
    tick(3);
    tests_run++;
    if (snap_switches !== 24'hA51234) begin
      tests_failed++;
      $display("FAIL press_snap: got %h, want a51234", snap_switches);
    end
    do_read(ADDR_SUBMIT, 1'b1, 1'b1);
    tick(10);
    tests_run++;
    if (submit_posedge !== 1'b0) begin
      tests_failed++;
      $display("FAIL held_no_repulse: got %b, want 0", submit_posedge);
    end
    btn_submit = 1'b0;
    tick(12);
    tests_run++;
    if (u_dut.u_submit_db.state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL release_idle: got %0d, want 0", u_dut.u_submit_db.state);
    end
  endtask

  task automatic test_bounce();
    btn_submit = 1'b1; tick();
    btn_submit = 1'b0; tick();
    btn_submit = 1'b1; tick();
    btn_submit = 1'b0; tick();
    tick(8);
    tests_run++;
    if (submit_posedge !== 1'b0) begin
      tests_failed++;
      $display("FAIL bounce_flag: got %b, want 0", submit_posedge);
    end
    tests_run++;
    if (u_dut.u_submit_db.state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL bounce_state: got %0d, want 0", u_dut.u_submit_db.state);
    end
  endtask

  task automatic test_clear();
    btn_submit = 1'b1;
    tick(8);
    tests_run++;
    if (submit_posedge !== 1'b1) begin
      tests_failed++;
      $display("FAIL clear_setup: got %b, want 1", submit_posedge);
    end
    do_read(ADDR_STATUS, 1'b1, 1'b1);
    tests_run++;
    if (submit_posedge !== 1'b1) begin
      tests_failed++;
      $display("FAIL clear_wrong_addr: got %b, want 1", submit_posedge);
    end
    do_read(ADDR_SUBMIT, 1'b1, 1'b0);
    tests_run++;
    if (submit_posedge !== 1'b1) begin
      tests_failed++;
      $display("FAIL clear_no_ioread: got %b, want 1", submit_posedge);
    end
    do_read(ADDR_SUBMIT, 1'b0, 1'b1);
    tests_run++;
    if (submit_posedge !== 1'b1) begin
      tests_failed++;
      $display("FAIL clear_no_ctrl: got %b, want 1", submit_posedge);
    end
    do_read(3'b010, 1'b1, 1'b1);
    tests_run++;
    if (submit_posedge !== 1'b1) begin
      tests_failed++;
      $display("FAIL clear_other_addr: got %b, want 1", submit_posedge);
    end
    do_read(ADDR_SUBMIT, 1'b1, 1'b1);
    tests_run++;
    if (submit_posedge !== 1'b0 || status_posedge !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_submit: got %b %b, want 0 0", submit_posedge, status_posedge);
    end
    btn_submit = 1'b0;
    tick(12);
  endtask

  task automatic test_back_to_back();
    switches   = 24'h123456;
    btn_submit = 1'b1;
    tick(6);
    SwitchCtrl = 1'b1;
    ioRead     = 1'b1;
    switchAddr = ADDR_SUBMIT;
    tick();
    SwitchCtrl = 1'b0;
    ioRead     = 1'b0;
    switchAddr = 3'b000;
    tests_run++;
    if (submit_posedge !== 1'b1 || snap_switches !== 24'h123456) begin
      tests_failed++;
      $display("FAIL set_beats_clear: got %b %h, want 1 123456", submit_posedge, snap_switches);
    end
    btn_submit = 1'b0;
    tick(12);
    switches   = 24'h654321;
    btn_submit = 1'b1;
    tick(8);
    tests_run++;
    if (submit_posedge !== 1'b1 || snap_switches !== 24'h654321) begin
      tests_failed++;
      $display("FAIL repress_snap: got %b %h, want 1 654321", submit_posedge, snap_switches);
    end
    btn_submit = 1'b0;
    tick(12);
    do_read(ADDR_SUBMIT, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_press();
    int n;
    btn_submit = 1'b1;
    tick(4);
    reset = 1'b1;
    tick();
    tests_run++;
    if (submit_posedge !== 1'b0 || status_posedge !== 1'b0 || snap_switches !== 24'h0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got %b %b %h, want 0 0 000000", submit_posedge, status_posedge, snap_switches);
    end
    reset = 1'b0;
    n = 0;
    while (submit_posedge !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    tests_run++;
    if (n !== 7) begin
      tests_failed++;
      $display("FAIL midreset_latency: got %0d cycles, want 7", n);
    end
    btn_submit = 1'b0;
    tick(12);
    do_read(ADDR_SUBMIT, 1'b1, 1'b1);
  endtask

  task automatic test_both_buttons();
    int n;
    btn_submit = 1'b1;
    btn_status = 1'b1;
    n = 0;
    while (submit_posedge !== 1'b1 && status_posedge !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    tests_run++;
    if (n !== 7 || submit_posedge !== 1'b1 || status_posedge !== 1'b1) begin
      tests_failed++;
      $display("FAIL both_set: got %0d cycles flags %b %b, want 7 cycles flags 1 1", n, submit_posedge, status_posedge);
    end
    do_read(ADDR_SUBMIT, 1'b1, 1'b1);
    tests_run++;
    if (submit_posedge !== 1'b0 || status_posedge !== 1'b1) begin
      tests_failed++;
      $display("FAIL both_clear_submit: got %b %b, want 0 1", submit_posedge, status_posedge);
    end
    do_read(ADDR_STATUS, 1'b1, 1'b1);
    tests_run++;
    if (submit_posedge !== 1'b0 || status_posedge !== 1'b0) begin
      tests_failed++;
      $display("FAIL both_clear_status: got %b %b, want 0 0", submit_posedge, status_posedge);
    end
    btn_submit = 1'b0;
    btn_status = 1'b0;
    tick(12);
  endtask

  initial begin
    tick();
    test_reset();
    test_clean_press();
    test_bounce();
    test_clear();
    test_back_to_back();
    test_reset_mid_press();
    test_both_buttons();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
